// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss-handling (line refill) stage.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_READ,
    WB_BEAT,
    RF_REQ,
    RF_WAIT,
    RF_WRITE,
    DONE
  } refill_state_e;

  // Number of memory beats needed to move one cache line.
  function automatic int calc_beats(input int dw, input int bw);
    return dw / bw;
  endfunction

endpackage

// File: rtl/cache_line_refill.sv
// Miss handler: optional victim write-back, then beat-by-beat refill and a
// single full-line install into the cache data array.
module cache_line_refill
  import cache_pkg::*;
#(
  parameter int DW  = 128,
  parameter int NUM = 8,
  parameter int BW  = 32,
  parameter int AW  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [$clog2(NUM)-1:0]  req_index,
  input  logic [AW-1:0]           req_addr,
  input  logic                    req_dirty,
  input  logic [AW-1:0]           req_wb_addr,
  output logic                    done,
  output logic                    da_read_en,
  output logic [$clog2(NUM)-1:0]  da_read_addr,
  input  logic [DW-1:0]           da_read_data,
  output logic                    da_write_en,
  output logic [DW/8-1:0]         da_write_byte_en,
  output logic [$clog2(NUM)-1:0]  da_write_addr,
  output logic [DW-1:0]           da_write_data,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [AW-1:0]           mem_req_addr,
  output logic [BW-1:0]           mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [BW-1:0]           mem_resp_rdata
);

  localparam int BEATS = calc_beats(DW, BW);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(DW / 8 - 1);

  refill_state_e          r_state;
  refill_state_e          w_next_state;
  logic [BCW-1:0]         r_beat;
  logic [DW-1:0]          r_lbuf;
  logic [$clog2(NUM)-1:0] r_index;
  logic [AW-1:0]          r_rf_addr;
  logic [AW-1:0]          r_wb_addr;

  logic                   w_last;
  logic [AW-1:0]          w_beat_off;
  logic [BW-1:0]          w_lbuf_beat;

  assign w_last      = (r_beat == BCW'(BEATS - 1));
  assign w_beat_off  = AW'(r_beat) * AW'(BW / 8);
  assign w_lbuf_beat = r_lbuf[r_beat*BW +: BW];

  // NOTE: the line buffer is reset along with the control state so that no
  // stale line can ever reach the data-array write port after a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_lbuf    <= '0;
      r_index   <= '0;
      r_rf_addr <= '0;
      r_wb_addr <= '0;
    end else begin
      // NOTE: all state uses non-blocking assignment so every branch below
      // sees the pre-edge values regardless of statement order.
      r_state <= w_next_state;
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_index   <= req_index;
            r_rf_addr <= req_addr & ALIGN_MASK;
            r_wb_addr <= req_wb_addr & ALIGN_MASK;
            r_beat    <= '0;
          end
        end
        WB_READ: r_lbuf <= da_read_data;
        WB_BEAT: begin
          if (mem_req_ready) r_beat <= w_last ? '0 : r_beat + BCW'(1);
        end
        RF_WAIT: begin
          if (mem_resp_valid) begin
            r_lbuf[r_beat*BW +: BW] <= mem_resp_rdata;
            if (!w_last) r_beat <= r_beat + BCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output and the next state get a default before the case, so
  // no path through this block can infer a latch.
  always_comb begin
    w_next_state     = r_state;
    req_ready        = 1'b0;
    done             = 1'b0;
    da_read_en       = 1'b0;
    da_read_addr     = '0;
    da_write_en      = 1'b0;
    da_write_byte_en = '0;
    da_write_addr    = '0;
    da_write_data    = '0;
    mem_req_valid    = 1'b0;
    mem_req_we       = 1'b0;
    mem_req_addr     = '0;
    mem_req_wdata    = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = req_dirty ? WB_READ : RF_REQ;
      end
      WB_READ: begin
        da_read_en   = 1'b1;
        da_read_addr = r_index;
        w_next_state = WB_BEAT;
      end
      WB_BEAT: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = r_wb_addr + w_beat_off;
        mem_req_wdata = w_lbuf_beat;
        if (mem_req_ready && w_last) w_next_state = RF_REQ;
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = r_rf_addr + w_beat_off;
        if (mem_req_ready) w_next_state = RF_WAIT;
      end
      RF_WAIT: begin
        if (mem_resp_valid) w_next_state = w_last ? RF_WRITE : RF_REQ;
      end
      RF_WRITE: begin
        da_write_en      = 1'b1;
        da_write_byte_en = '1;
        da_write_addr    = r_index;
        da_write_data    = r_lbuf;
        w_next_state     = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_refill.sv
// Scoreboard bench for cache_line_refill: a line-level reference model queues
// expected memory beats, installs and done pulses; a monitor checks them.
module tb_cache_line_refill;

  localparam int DW = 128, NUM = 8, BW = 32, AW = 32;
  localparam int IW = $clog2(NUM);
  localparam int BEATS = DW / BW;
  localparam int LINE_BYTES = DW / 8;
  localparam int BEAT_BYTES = BW / 8;
  localparam logic [BW-1:0] BAD = 32'hBAD0BAD0;
  localparam logic [219:0] RST_OUTS = {1'b1, 219'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 0, req_dirty = 0, req_ready, done;
  logic [IW-1:0] req_index = '0;
  logic [AW-1:0] req_addr = '0, req_wb_addr = '0;
  logic da_read_en, da_write_en;
  logic [IW-1:0] da_read_addr, da_write_addr;
  logic [DW-1:0] da_read_data, da_write_data;
  logic [DW/8-1:0] da_write_byte_en;
  logic mem_req_valid, mem_req_we;
  logic mem_req_ready = 0, mem_resp_valid = 0;
  logic [AW-1:0] mem_req_addr;
  logic [BW-1:0] mem_req_wdata, mem_resp_rdata = '0;

  always #5 clk = ~clk;

  cache_line_refill #(.DW(DW), .NUM(NUM), .BW(BW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_addr(req_addr), .req_dirty(req_dirty), .req_wb_addr(req_wb_addr),
    .done(done),
    .da_read_en(da_read_en), .da_read_addr(da_read_addr), .da_read_data(da_read_data),
    .da_write_en(da_write_en), .da_write_byte_en(da_write_byte_en),
    .da_write_addr(da_write_addr), .da_write_data(da_write_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  // Data array next to the DUT: combinational read, byte-enabled write.
  logic [DW-1:0] da_mem [NUM];
  assign da_read_data = da_mem[da_read_addr];
  always @(posedge clk)
    if (da_write_en)
      for (int k = 0; k < DW / 8; k++)
        if (da_write_byte_en[k]) da_mem[da_write_addr][k*8 +: 8] <= da_write_data[k*8 +: 8];

  typedef struct { logic we; logic [AW-1:0] addr; logic [BW-1:0] wdata; } mem_op_t;
  typedef struct { logic [IW-1:0] idx; logic [DW-1:0] line; } line_wr_t;

  mem_op_t  exp_mem [$];
  line_wr_t exp_wr  [$];
  int       exp_done[$];
  logic [DW-1:0] ref_arr [NUM];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, acc_cycle = 0, done_count = 0, da_wr_count = 0, rd_ops = 0, wr_ops = 0;
  int mem_mode = 0;  // 0 ideal, 1 three-cycle backpressure, 2 random
  int spur_pct = 0;
  bit pattern_mode = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [BW-1:0] mem_word(input logic [AW-1:0] a);
    if (pattern_mode) return 32'h11111111 * (32'(a[3:2]) + 32'd1);
    return (a * 32'h9E3779B1) ^ 32'h5EEDC0DE;
  endfunction

  function automatic logic [219:0] out_vec();
    return {req_ready, done, da_read_en, da_read_addr, da_write_en, da_write_byte_en,
            da_write_addr, da_write_data, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata};
  endfunction

  // Memory: responds 1..3 cycles after a read handshake; may pulse BAD
  // responses whenever no genuine response is outstanding.
  initial begin
    int resp_cnt, stall;
    logic [BW-1:0] resp_data;
    resp_cnt = 0; stall = 0; resp_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        resp_cnt = 0; stall = 0;
        mem_resp_valid = 0; mem_req_ready = 0;
      end else begin
        mem_resp_valid = 0;
        mem_resp_rdata = BAD;
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin mem_resp_valid = 1; mem_resp_rdata = resp_data; end
        end else if (spur_pct > 0 && $urandom_range(0, 99) < spur_pct) begin
          mem_resp_valid = 1;
        end
        case (mem_mode)
          0: mem_req_ready = 1;
          1: begin
            mem_req_ready = 0;
            if (mem_req_valid) begin
              if (stall < 3) stall++;
              else begin mem_req_ready = 1; stall = 0; end
            end
          end
          default: mem_req_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (mem_req_valid && mem_req_ready && !mem_req_we) begin
          resp_cnt  = (mem_mode == 0) ? 1 : $urandom_range(1, 3);
          resp_data = mem_word(mem_req_addr);
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    bit stall_prev;
    logic [96:0] stall_vec;
    mem_op_t e;
    line_wr_t w;
    int lat, nbad;
    stall_prev = 0; stall_vec = '0;
    forever begin
      @(negedge clk);
      if (rst) stall_prev = 0;
      else begin
        if (req_valid && req_ready) acc_cycle = cyc;
        if (stall_prev)
          check("stall_stable", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, stall_vec);
        stall_prev = mem_req_valid && !mem_req_ready;
        stall_vec  = {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata};
        if (mem_req_valid && mem_req_ready) begin
          if (mem_req_we) wr_ops++; else rd_ops++;
          if (exp_mem.size() == 0) check("mem_unexpected", {mem_req_we, mem_req_addr}, 0);
          else begin
            e = exp_mem.pop_front();
            check("mem_beat", {mem_req_we, mem_req_addr, mem_req_we ? mem_req_wdata : 32'h0},
                  {e.we, e.addr, e.wdata});
          end
        end
        if (da_write_en) begin
          da_wr_count++;
          if (exp_wr.size() == 0) check("install_unexpected", {da_write_addr, da_write_data}, 0);
          else begin
            w = exp_wr.pop_front();
            check("install", {da_write_byte_en, da_write_addr, da_write_data},
                  {{(DW/8){1'b1}}, w.idx, w.line});
            if (spur_pct > 0) begin
              nbad = 0;
              for (int b = 0; b < BEATS; b++) if (da_write_data[b*BW +: BW] == BAD) nbad++;
              check("no_spurious_word", nbad, 0);
            end
          end
        end
        if (done) begin
          done_count++;
          if (exp_done.size() == 0) check("done_unexpected", 1, 0);
          else begin
            lat = exp_done.pop_front();
            if (lat >= 0) check("done_latency", cyc - acc_cycle, lat);
          end
        end
      end
    end
  end

  // Reference model: a miss is a list of memory beats plus one line install.
  task automatic model_miss(input int idx, input logic [AW-1:0] addr, input logic dirty,
                            input logic [AW-1:0] wb, input int lat);
    logic [AW-1:0] rf_base, wb_base;
    logic [DW-1:0] line;
    rf_base = addr - (addr % LINE_BYTES);
    wb_base = wb - (wb % LINE_BYTES);
    if (dirty)
      for (int b = 0; b < BEATS; b++)
        exp_mem.push_back('{1'b1, wb_base + AW'(b * BEAT_BYTES), ref_arr[idx][b*BW +: BW]});
    for (int b = 0; b < BEATS; b++) begin
      exp_mem.push_back('{1'b0, rf_base + AW'(b * BEAT_BYTES), '0});
      line[b*BW +: BW] = mem_word(rf_base + AW'(b * BEAT_BYTES));
    end
    exp_wr.push_back('{IW'(idx), line});
    ref_arr[idx] = line;
    exp_done.push_back(lat);
  endtask

  task automatic issue(input int idx, input logic [AW-1:0] addr, input logic dirty,
                       input logic [AW-1:0] wb, input int lat, input bit noisy);
    bit acc;
    model_miss(idx, addr, dirty, wb, lat);
    req_valid = 1; req_index = IW'(idx); req_addr = addr; req_dirty = dirty; req_wb_addr = wb;
    acc = 0;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = req_ready;
      @(posedge clk); #2;
    end
    if (!acc) check("accept_timeout", 0, 1);
    if (noisy) begin
      req_index = IW'($urandom); req_addr = $urandom; req_dirty = 1'($urandom);
      repeat (2) begin @(posedge clk); #2; end
    end
    req_valid = 0;
  endtask

  task automatic run_miss(input int idx, input logic [AW-1:0] addr, input logic dirty,
                          input logic [AW-1:0] wb, input int lat, input bit noisy);
    int dc0;
    bit seen;
    dc0 = done_count;
    issue(idx, addr, dirty, wb, lat, noisy);
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = (done_count > dc0);
    end
    if (!seen) check("done_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  initial begin
    int rd0, wr0, wrc;
    logic [DW-1:0] saved;
    logic [AW-1:0] a;
    bit hit;
    for (int i = 0; i < NUM; i++) begin
      ref_arr[i] = {$urandom, $urandom, $urandom, $urandom};
      da_mem[i]  = ref_arr[i];
    end
    ref_arr[5] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    da_mem[5]  = ref_arr[5];

    repeat (2) @(posedge clk);
    #2 check("reset_outputs", out_vec(), RST_OUTS);
    rst = 0;
    @(posedge clk); #2;
    check("idle_outputs", out_vec(), RST_OUTS);

    // Directed clean and dirty misses with an ideal memory.
    run_miss(3, 32'h1004, 0, 32'h0, 2 * BEATS + 2, 0);
    check("clean_line3", da_mem[3], 128'h44444444_33333333_22222222_11111111);
    run_miss(5, 32'h3000, 1, 32'h2000, 3 * BEATS + 3, 0);

    // Backpressure: exact beat counts with three stall cycles per beat.
    mem_mode = 1; rd0 = rd_ops; wr0 = wr_ops;
    run_miss(1, 32'h0000_7A30, 1, 32'h0000_9B10, -1, 0);
    check("bp_write_beats", wr_ops - wr0, BEATS);
    check("bp_read_beats", rd_ops - rd0, BEATS);
    mem_mode = 0;

    // Spurious responses in every cycle outside RF_WAIT.
    spur_pct = 100;
    run_miss(4, 32'h0000_4440, 0, 32'h0, 2 * BEATS + 2, 0);
    run_miss(0, 32'h0000_5550, 1, 32'h0000_6660, 3 * BEATS + 3, 0);
    spur_pct = 0;

    // Address wrap at the top of the address space.
    run_miss(2, 32'hFFFF_FFF0, 1, 32'hFFFF_FFF8, 3 * BEATS + 3, 0);

    // Reset during the beat-2 response wait.
    saved = ref_arr[6];
    rd0 = rd_ops;
    issue(6, 32'h0000_4000, 0, 32'h0, -1, 0);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (rd_ops >= rd0 + 3);
    end
    if (!hit) check("rst_wait_timeout", 0, 1);
    @(posedge clk); #3;
    rst = 1;
    #1 check("mid_reset_outputs", out_vec(), RST_OUTS);
    exp_mem.delete(); exp_wr.delete(); exp_done.delete();
    ref_arr[6] = saved;
    wrc = da_wr_count;
    repeat (3) @(posedge clk);
    #3 rst = 0;
    check("rst_no_write", da_wr_count, wrc);
    check("rst_line6_intact", da_mem[6], saved);
    @(posedge clk); #2;
    run_miss(6, 32'h0000_5000, 1, 32'h0000_6000, 3 * BEATS + 3, 0);

    // Randomised misses: random memory timing, hash data, stray responses.
    mem_mode = 2; pattern_mode = 0; spur_pct = 30;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      run_miss($urandom_range(0, NUM - 1), a, 1'($urandom), $urandom, -1, 1'($urandom));
    end

    repeat (4) @(posedge clk);
    check("mem_queue_empty", exp_mem.size(), 0);
    check("install_queue_empty", exp_wr.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);
    for (int i = 0; i < NUM; i++) check("final_array", da_mem[i], ref_arr[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_line_refill.md
Name: cache_line_refill

Overview:
- Miss-handling stage sitting directly upstream of the cache data array.
- On a miss request it optionally writes back the victim line: reads it from the data array and sends it to memory beat-by-beat.
- It then fetches the new line from memory beat-by-beat, assembles it, and writes it into the data array in one full-line write.
- One miss is in flight at a time; a `done` pulse tells the cache controller the line is installed.

Parameters:
- DW, 128, cache line width in bits; must be a multiple of BW.
- NUM, 8, number of lines in the data array.
- BW, 32, memory beat width in bits; must be a multiple of 8.
- AW, 32, memory byte-address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  miss request valid.
- req_ready  out  1  block idle, can accept a request.
- req_index  in  $clog2(NUM)  data-array line index to fill.
- req_addr  in  AW  refill line byte address; low $clog2(DW/8) bits ignored.
- req_dirty  in  1  victim line must be written back first.
- req_wb_addr  in  AW  victim line byte address; low $clog2(DW/8) bits ignored.
- done  out  1  one-cycle pulse: line installed.
- da_read_en  out  1  data-array read enable.
- da_read_addr  out  $clog2(NUM)  data-array read index.
- da_read_data  in  DW  data-array read data, combinational, same cycle.
- da_write_en  out  1  data-array write enable.
- da_write_byte_en  out  DW/8  byte enables; all-ones when writing.
- da_write_addr  out  $clog2(NUM)  data-array write index.
- da_write_data  out  DW  assembled line.
- mem_req_valid  out  1  memory beat request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  1 = write beat, 0 = read beat.
- mem_req_addr  out  AW  beat byte address.
- mem_req_wdata  out  BW  write beat data.
- mem_resp_valid  in  1  read response valid.
- mem_resp_rdata  in  BW  read response data.

Behaviour:
- Constants: BEATS = DW/BW. Beat counter `beat` is $clog2(BEATS) bits (minimum 1). Line buffer `lbuf` is DW bits.
- Reset (asynchronous, rst=1):
  - state IDLE; beat 0; lbuf 0; latched index/addresses/dirty 0.
  - Outputs: req_ready=1 (it is state-decoded); all other outputs 0, including done, da_*, and mem_req_*.
  - Reset asserted mid-operation abandons the miss immediately; no partial data-array write occurs.
- Outputs are decoded from state, beat, lbuf and the latched request.
- Beat b address = {latched_line_addr[AW-1:$clog2(DW/8)], zeros} + b*(BW/8). Beat b occupies lbuf[b*BW +: BW] (beat 0 = LSBs).
- IDLE:
  - req_ready=1.
  - On req_valid: latch index, aligned addresses and dirty; beat←0.
  - Go to WB_READ if dirty, else RF_REQ.
- WB_READ (1 cycle):
  - da_read_en=1, da_read_addr=index; lbuf←da_read_data.
  - Next state WB_BEAT.
- WB_BEAT:
  - mem_req_valid=1, we=1, addr=wb beat address, wdata=lbuf slice[beat].
  - On mem_req_ready: if beat==BEATS-1, then beat←0 and go to RF_REQ; else beat++.
- RF_REQ:
  - mem_req_valid=1, we=0, addr=refill beat address.
  - On mem_req_ready go to RF_WAIT.
- RF_WAIT:
  - On mem_resp_valid: lbuf slice[beat]←mem_resp_rdata.
  - If beat==BEATS-1, go to RF_WRITE; else beat++ and return to RF_REQ.
- RF_WRITE (1 cycle):
  - da_write_en=1, byte_en all ones, addr=index, data=lbuf.
  - Next state DONE.
- DONE (1 cycle): done=1, then IDLE.
- Handshake rules:
  - mem_req_valid stays high with stable addr/we/wdata until mem_req_ready.
  - mem_resp_valid is ignored in every state except RF_WAIT. A response in the same cycle as the request handshake is therefore ignored; memory must respond at least one cycle later.
  - req_valid outside IDLE is ignored. The caller must hold its request until req_ready.
- Latency, memory with ready=1 and response one cycle later, request accepted in cycle 0:
  - Clean miss: done in cycle 2*BEATS+2 (cycle 10 with defaults).
  - Dirty miss: adds 1+BEATS cycles (done in cycle 15).
- The write-back always completes before any refill read is issued (read-after-write ordering to memory).
- Address addition wraps modulo 2^AW.

Decomposition:
- Shared package `cache_pkg`:
  - refill_state_e enum {IDLE, WB_READ, WB_BEAT, RF_REQ, RF_WAIT, RF_WRITE, DONE}.
  - Function computing BEATS from DW/BW.
- No sub-module; the line buffer and FSM stay in one module. The bench instantiates the existing data array alongside it.

Test Plan:
- Clean miss: req_index=3, req_addr=0x1004, memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Read addresses are 0x1000, 0x1004, 0x1008, 0x100C.
  - The data array line 3 write is 0x44444444_33333333_22222222_11111111 with byte_en=16'hFFFF.
  - done pulses in cycle 10.
- Dirty miss: line 5 preloaded 0xDDDD…_CCCC…_BBBB…_AAAA…, req_wb_addr=0x2000.
  - Writes go to 0x2000/04/08/0C with data AAAA…, BBBB…, CCCC…, DDDD… in that order, strictly before the first read.
  - done pulses in cycle 15.
- Backpressure: mem_req_ready low 3 cycles on each beat.
  - mem_req_valid, addr and wdata stay stable throughout.
  - The beat count is exact (4 writes, 4 reads).
- Spurious response: mem_resp_valid pulsed in IDLE and in RF_REQ with 0xBAD0BAD0 -> value never appears in the installed line.
- Reset mid-refill: rst asserted during beat 2 of RF_WAIT.
  - All outputs go to 0 asynchronously with req_ready=1, and there is no da_write_en.
  - A next request completes normally.
- Wrap: req_addr=0xFFFFFFF0 -> beat addresses 0xFFFFFFF0, F4, F8, FC; no overflow into other fields.
